axi_xact_sched: RTL
===================

# axi_xact_sched

Transaction scheduler for the AXI packet generator/checker pair. It creates write transactions (address, length) for the packet generator. It forwards each completed write, in order, as a read transaction to `axi_pkt_chk`, which re-reads and compares the same region. It bounds the number of outstanding write-then-check packets, counts results and reports pass/fail to the test-control logic.

## Interface
Parameters:
- `TGT_ADDR_WIDTH`, 16: width of the transaction address.
- `LEN_MAX`, 15: largest AXI burst length (`axlen`) issued; range 0–255.
- `MAX_OUTSTANDING`, 4: maximum packets issued but not yet compared; range 1 to `FIFO_DEPTH`.
- `FIFO_DEPTH`, 8: depth of the internal write-pending and read-pending queues; power of 2.
- `NUM_PKTS`, 0: packets per run; 0 means run until `i_stop`.

Ports:
- `i_clk`  in  1  single clock.
- `i_reset_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  pulse; starts a run.
- `i_stop`  in  1  pulse; ends issuing and drains outstanding packets.
- `o_wr_xact_avail`  out  1  write transaction available.
- `i_wr_xact_read`  in  1  generator pops a write transaction.
- `o_wr_xact_addr`  out  `TGT_ADDR_WIDTH`  write address.
- `o_wr_xact_len`  out  8  write burst length.
- `i_wr_pkt_done`  in  1  pulse; the oldest issued write has received its B response.
- `o_rd_xact_avail`  out  1  read transaction available (to checker `i_xact_avail`).
- `i_rd_xact_read`  in  1  checker pops a read transaction.
- `o_rd_xact_addr`  out  `TGT_ADDR_WIDTH`  read address.
- `o_rd_xact_len`  out  8  read burst length.
- `i_pkt_compared`  in  1  pulse; the checker finished comparing one packet.
- `i_pkt_error`  in  1  checker error level (sticky in the checker).
- `o_busy`  out  1  state is RUN or DRAIN.
- `o_done`  out  1  state is DONE.
- `o_fail`  out  1  sticky failure.
- `o_pkts_checked`  out  32  packets compared in the current run.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
  - IDLE: waits for `i_start`.
  - `i_start` in IDLE or DONE: go to RUN. Clears counters, `o_fail`, both queues and the generator index.
  - RUN: issues writes. Goes to DRAIN on `i_stop`, or when `issued == NUM_PKTS` with `NUM_PKTS != 0`.
  - DRAIN: issues no new writes. Goes to DONE when `compared == issued`.
  - DONE: holds until `i_start`.
  - `i_start` in RUN or DRAIN is ignored.
  - `i_stop` in IDLE, DRAIN or DONE is ignored.
  - If `i_stop` and the `NUM_PKTS` limit occur in the same cycle, go to DRAIN.
- **Write address/length generation:**
  - Packet index k starts at 0.
  - len(k) = k mod (`LEN_MAX`+1).
  - addr(0) = 0; addr(k+1) = addr(k) + len(k) + 1, modulo 2^`TGT_ADDR_WIDTH`, so it wraps silently.
  - The address unit is one data beat; the checker adds the byte offset.
- **Write issue:**
  - `o_wr_xact_avail` = state RUN && `(issued - compared) < MAX_OUTSTANDING` && write-pending queue not full.
  - A pop when `o_wr_xact_avail` is high pushes {addr, len} into the write-pending queue and increments issued and k.
  - A pop while `o_wr_xact_avail` is low is ignored.
- **Write completion:**
  - `i_wr_pkt_done` moves the head of the write-pending queue to the tail of the read-pending queue.
  - `i_wr_pkt_done` with the write-pending queue empty sets `o_fail`.
- **Read issue:**
  - `o_rd_xact_avail` = read-pending queue not empty.
  - A pop when `o_rd_xact_avail` is high removes the head entry.
  - A pop when the queue is empty is ignored; outputs hold.
- **Compare:**
  - `i_pkt_compared` increments compared and `o_pkts_checked`.
  - If compared already equals issued, `i_pkt_compared` sets `o_fail` and compared does not change.
  - `i_pkt_error` high in any non-IDLE state sets `o_fail`.
  - `o_fail` is cleared only by reset or `i_start`.
- **Simultaneous events:**
  - A same-cycle push and pop on either queue are both honoured; occupancy is unchanged.
  - Queue overflow cannot occur because of the `MAX_OUTSTANDING` ≤ `FIFO_DEPTH` constraint.
- **Counter widths:** issued, compared and k are 32 bits; the outstanding difference is computed modulo 2^32.

## Timing
- **Reset:** `i_reset_n` low asynchronously forces:
  - state IDLE;
  - all avail, addr and len outputs to 0;
  - `o_busy`, `o_done` and `o_fail` to 0;
  - `o_pkts_checked` to 0;
  - both queues empty.
- A reset mid-run discards all queued transactions.
- **Transaction outputs:**
  - Both transaction ports use non-show-ahead FIFO semantics: addr and len update in the cycle after the pop and hold until the next pop.
  - This matches the checker, which samples addr and len two cycles after its pop pulse.
- **Avail timing:**
  - All avail outputs are registered.
  - `o_wr_xact_avail` deasserts the cycle after the pop that reaches the outstanding limit.
  - `o_rd_xact_avail` asserts the cycle after `i_wr_pkt_done`.
- **Status timing:**
  - The `i_pkt_compared` → `o_pkts_checked` update latency is 1 cycle.
  - DRAIN→DONE occurs 1 cycle after the final compare; `o_done` is registered.

## Test plan
- **Basic run:** `NUM_PKTS`=3, ideal generator/checker → writes at (addr, len) = (0,0), (1,1), (3,2). Reads in the same order. `o_done`=1, `o_pkts_checked`=3, `o_fail`=0.
- **Credit limit:** hold `i_wr_pkt_done` low → exactly `MAX_OUTSTANDING`=4 writes popped, then `o_wr_xact_avail`=0. One done and one compare → avail reasserts 1 cycle later.
- **Address wrap:** `TGT_ADDR_WIDTH`=4, `LEN_MAX`=15 → the 6th packet address is 15 mod 16 = 15. The 7th address wraps to 15+6 mod 16 = 5.
- **Stop/drain:** `NUM_PKTS`=0; `i_stop` pulse with 2 outstanding → no further write avail. `o_busy` stays 1 until 2 compares, then `o_done`=1.
- **Errors:** `i_pkt_error`=1 during RUN → `o_fail`=1, held through DONE, cleared by `i_start`. A spurious `i_pkt_compared` with 0 outstanding → `o_fail`=1.
- **Async reset mid-run:** assert `i_reset_n`=0 with queues non-empty → all outputs 0 immediately. After release with `i_start`, the first write is (0,0).

Source files
------------

// File: rtl/axi_xact_sched.sv
// Transaction scheduler: generates write bursts for the packet generator, forwards completed
// writes in order as read bursts to the checker, and tracks outstanding/compared packets.
module axi_xact_sched #(
    parameter int TGT_ADDR_WIDTH  = 16,
    parameter int LEN_MAX         = 15,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FIFO_DEPTH      = 8,
    parameter int NUM_PKTS        = 0
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_start,
    input  logic                      i_stop,
    output logic                      o_wr_xact_avail,
    input  logic                      i_wr_xact_read,
    output logic [TGT_ADDR_WIDTH-1:0] o_wr_xact_addr,
    output logic [7:0]                o_wr_xact_len,
    input  logic                      i_wr_pkt_done,
    output logic                      o_rd_xact_avail,
    input  logic                      i_rd_xact_read,
    output logic [TGT_ADDR_WIDTH-1:0] o_rd_xact_addr,
    output logic [7:0]                o_rd_xact_len,
    input  logic                      i_pkt_compared,
    input  logic                      i_pkt_error,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_fail,
    output logic [31:0]               o_pkts_checked
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = TGT_ADDR_WIDTH + 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]               issued_reg, issued_next;
    logic [31:0]               compared_reg, compared_next;
    logic [TGT_ADDR_WIDTH-1:0] gen_addr_reg, gen_addr_next;
    logic [7:0]                gen_len_reg, gen_len_next;
    logic                      fail_reg, fail_next;
    logic                      wr_avail_reg, wr_avail_next;
    logic                      rd_avail_reg, rd_avail_next;
    logic                      busy_reg, done_reg;

    logic [TGT_ADDR_WIDTH-1:0] wr_addr_reg, rd_addr_reg;
    logic [7:0]                wr_len_reg, rd_len_reg;

    // Write-pending queue holds issued writes awaiting B; read-pending holds writes awaiting re-read.
    logic [ENT_W-1:0] wq_mem [FIFO_DEPTH];
    logic [ENT_W-1:0] rq_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wq_wptr_reg, wq_wptr_next, wq_rptr_reg, wq_rptr_next;
    logic [PTR_W-1:0] rq_wptr_reg, rq_wptr_next, rq_rptr_reg, rq_rptr_next;
    logic [PTR_W:0]   wq_cnt_reg, wq_cnt_next, rq_cnt_reg, rq_cnt_next;

    logic start_acc;
    logic wq_push, wq_pop, rq_push, rq_pop, cmp_ok;
    logic wq_empty, rq_empty;

    assign wq_empty = (wq_cnt_reg == '0);
    assign rq_empty = (rq_cnt_reg == '0);

    // Events are qualified here; a start in IDLE/DONE overrides everything else that cycle.
    always_comb begin
        start_acc = i_start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
        wq_push   = !start_acc && i_wr_xact_read && wr_avail_reg;
        wq_pop    = !start_acc && i_wr_pkt_done && !wq_empty;
        rq_push   = wq_pop;
        rq_pop    = !start_acc && i_rd_xact_read && !rq_empty;
        cmp_ok    = !start_acc && i_pkt_compared && (compared_reg != issued_reg);
    end

    always_comb begin
        issued_next   = issued_reg;
        compared_next = compared_reg;
        gen_addr_next = gen_addr_reg;
        gen_len_next  = gen_len_reg;
        fail_next     = fail_reg;
        wq_wptr_next  = wq_wptr_reg;
        wq_rptr_next  = wq_rptr_reg;
        rq_wptr_next  = rq_wptr_reg;
        rq_rptr_next  = rq_rptr_reg;
        wq_cnt_next   = wq_cnt_reg;
        rq_cnt_next   = rq_cnt_reg;
        state_next    = state_reg;

        if (start_acc) begin
            issued_next   = '0;
            compared_next = '0;
            gen_addr_next = '0;
            gen_len_next  = '0;
            fail_next     = 1'b0;
            wq_wptr_next  = '0;
            wq_rptr_next  = '0;
            rq_wptr_next  = '0;
            rq_rptr_next  = '0;
            wq_cnt_next   = '0;
            rq_cnt_next   = '0;
            state_next    = ST_RUN;
        end else begin
            if (wq_push) begin
                issued_next   = issued_reg + 32'd1;
                gen_addr_next = gen_addr_reg + TGT_ADDR_WIDTH'(gen_len_reg) + TGT_ADDR_WIDTH'(1);
                gen_len_next  = (gen_len_reg == 8'(LEN_MAX)) ? 8'd0 : gen_len_reg + 8'd1;
                wq_wptr_next  = wq_wptr_reg + PTR_W'(1);
            end
            if (wq_pop) begin
                wq_rptr_next = wq_rptr_reg + PTR_W'(1);
                rq_wptr_next = rq_wptr_reg + PTR_W'(1);
            end
            if (rq_pop) begin
                rq_rptr_next = rq_rptr_reg + PTR_W'(1);
            end

            case ({wq_push, wq_pop})
                2'b10:   wq_cnt_next = wq_cnt_reg + (PTR_W + 1)'(1);
                2'b01:   wq_cnt_next = wq_cnt_reg - (PTR_W + 1)'(1);
                default: wq_cnt_next = wq_cnt_reg;
            endcase
            case ({rq_push, rq_pop})
                2'b10:   rq_cnt_next = rq_cnt_reg + (PTR_W + 1)'(1);
                2'b01:   rq_cnt_next = rq_cnt_reg - (PTR_W + 1)'(1);
                default: rq_cnt_next = rq_cnt_reg;
            endcase

            if (cmp_ok) begin
                compared_next = compared_reg + 32'd1;
            end

            if ((i_wr_pkt_done && wq_empty) ||
                (i_pkt_compared && (compared_reg == issued_reg)) ||
                (i_pkt_error && (state_reg != ST_IDLE))) begin
                fail_next = 1'b1;
            end

            // Transitions look at the post-update counts so the limit and DONE take effect on the same edge.
            case (state_reg)
                ST_RUN: begin
                    if (i_stop || ((NUM_PKTS != 0) && (issued_next == 32'(NUM_PKTS)))) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (compared_next == issued_next) begin
                        state_next = ST_DONE;
                    end
                end
                default: state_next = state_reg;
            endcase
        end

        wr_avail_next = (state_next == ST_RUN) &&
                        ((issued_next - compared_next) < 32'(MAX_OUTSTANDING)) &&
                        (wq_cnt_next != (PTR_W + 1)'(FIFO_DEPTH));
        rd_avail_next = (rq_cnt_next != '0);
    end

    // Queue storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge i_clk) begin
        if (wq_push) begin
            wq_mem[wq_wptr_reg] <= {gen_addr_reg, gen_len_reg};
        end
        if (rq_push) begin
            rq_mem[rq_wptr_reg] <= wq_mem[wq_rptr_reg];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg    <= ST_IDLE;
            issued_reg   <= '0;
            compared_reg <= '0;
            gen_addr_reg <= '0;
            gen_len_reg  <= '0;
            fail_reg     <= 1'b0;
            wr_avail_reg <= 1'b0;
            rd_avail_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            wq_wptr_reg  <= '0;
            wq_rptr_reg  <= '0;
            rq_wptr_reg  <= '0;
            rq_rptr_reg  <= '0;
            wq_cnt_reg   <= '0;
            rq_cnt_reg   <= '0;
            wr_addr_reg  <= '0;
            wr_len_reg   <= '0;
            rd_addr_reg  <= '0;
            rd_len_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            issued_reg   <= issued_next;
            compared_reg <= compared_next;
            gen_addr_reg <= gen_addr_next;
            gen_len_reg  <= gen_len_next;
            fail_reg     <= fail_next;
            wr_avail_reg <= wr_avail_next;
            rd_avail_reg <= rd_avail_next;
            busy_reg     <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            done_reg     <= (state_next == ST_DONE);
            wq_wptr_reg  <= wq_wptr_next;
            wq_rptr_reg  <= wq_rptr_next;
            rq_wptr_reg  <= rq_wptr_next;
            rq_rptr_reg  <= rq_rptr_next;
            wq_cnt_reg   <= wq_cnt_next;
            rq_cnt_reg   <= rq_cnt_next;
            // Non-show-ahead ports: the popped entry appears the cycle after the pop.
            if (wq_push) begin
                wr_addr_reg <= gen_addr_reg;
                wr_len_reg  <= gen_len_reg;
            end
            if (rq_pop) begin
                rd_addr_reg <= rq_mem[rq_rptr_reg][ENT_W-1:8];
                rd_len_reg  <= rq_mem[rq_rptr_reg][7:0];
            end
        end
    end

    assign o_wr_xact_avail = wr_avail_reg;
    assign o_wr_xact_addr  = wr_addr_reg;
    assign o_wr_xact_len   = wr_len_reg;
    assign o_rd_xact_avail = rd_avail_reg;
    assign o_rd_xact_addr  = rd_addr_reg;
    assign o_rd_xact_len   = rd_len_reg;
    assign o_busy          = busy_reg;
    assign o_done          = done_reg;
    assign o_fail          = fail_reg;
    assign o_pkts_checked  = compared_reg;

endmodule
